// File: rtl/dec_down_counter_pkg.sv
// Shared BCD constants and helpers for the decimal down-counter chain.
package dec_down_counter_pkg;

    localparam int               BCD_W    = 4;
    localparam logic [BCD_W-1:0] BCD_MAX  = 4'd9;
    localparam logic [BCD_W-1:0] BCD_ZERO = 4'd0;

    // Clamp a raw nibble into the legal BCD range so no digit ever holds A..F.
    function automatic logic [BCD_W-1:0] bcd_sat(input logic [BCD_W-1:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/dec_down_digit.sv
// One BCD digit of the down-counter chain. Load beats wrap, and wrap beats
// borrow. Borrow-out fires when this digit sits at 0 and is asked to decrement.
module dec_down_digit
    import dec_down_counter_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [BCD_W-1:0] load_digit,
    input  logic             wrap_ld,
    input  logic [BCD_W-1:0] wrap_digit,
    input  logic             borrow_in,
    output logic [BCD_W-1:0] digit,
    output logic             borrow_out
);

    logic [BCD_W-1:0] r_digit;

    // Digit register: preset, whole-counter wrap value, or decrement with borrow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_digit <= BCD_ZERO;
        else if (load)
            r_digit <= load_digit;
        else if (wrap_ld)
            r_digit <= wrap_digit;
        else if (borrow_in)
            r_digit <= (r_digit == BCD_ZERO) ? BCD_MAX : r_digit - 4'd1;
    end

    assign digit      = r_digit;
    assign borrow_out = borrow_in & (r_digit == BCD_ZERO);

endmodule

// File: rtl/dec_down_counter.sv
// Cascadable multi-digit BCD down-counter with a one-cycle wrap pulse.
// Optional feature macro: DEC_DOWN_AUTO_RELOAD_EN -- when defined, the
// counter wraps to the last (saturated) preset instead of all nines.
module dec_down_counter
    import dec_down_counter_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [BCD_W*DIGITS-1:0] load_val,
    input  logic                    en,
    output logic [BCD_W*DIGITS-1:0] count,
    output logic                    zero,
    output logic                    wrap
);

    logic [DIGITS:0]             w_borrow;
    logic [BCD_W*DIGITS-1:0]     w_load_sat;
    logic [BCD_W*DIGITS-1:0]     w_wrap_val;
    logic                        w_wrap_cond;
    logic                        r_wrap;

    // A decrement request enters at digit 0; load suppresses counting.
    assign w_borrow[0] = en & ~load;

    // A borrow escaping the top digit means the whole count was zero.
    assign w_wrap_cond = w_borrow[DIGITS];

    assign zero = (count == '0);

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_digit
            assign w_load_sat[BCD_W*g +: BCD_W] = bcd_sat(load_val[BCD_W*g +: BCD_W]);

            dec_down_digit u_digit (
                .clk        (clk),
                .reset      (reset),
                .load       (load),
                .load_digit (w_load_sat[BCD_W*g +: BCD_W]),
                .wrap_ld    (w_wrap_cond),
                .wrap_digit (w_wrap_val[BCD_W*g +: BCD_W]),
                .borrow_in  (w_borrow[g]),
                .digit      (count[BCD_W*g +: BCD_W]),
                .borrow_out (w_borrow[g+1])
            );
        end
    endgenerate

`ifdef DEC_DOWN_AUTO_RELOAD_EN
    logic [BCD_W*DIGITS-1:0] r_reload;

    // Remember the last preset so the wrap restarts the countdown from it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_reload <= '0;
        else if (load)
            r_reload <= w_load_sat;
    end

    assign w_wrap_val = r_reload;
`else
    assign w_wrap_val = {DIGITS{BCD_MAX}};
`endif

    // Wrap pulse: high only for the cycle after a decrement from all-zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_wrap <= 1'b0;
        else
            r_wrap <= w_wrap_cond;
    end

    assign wrap = r_wrap;

endmodule

// File: tb/tb_dec_down_counter.sv
// Directed bench for dec_down_counter, DIGITS=2.
module tb_dec_down_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic       load;
    logic       en;
    logic [7:0] load_val;
    logic [7:0] count;
    logic       zero;
    logic       wrap;

    int checks = 0;
    int errors = 0;

`ifdef DEC_DOWN_AUTO_RELOAD_EN
    localparam logic [7:0] WRAP_01_A = 8'h01;
    localparam logic [7:0] WRAP_01_B = 8'h00;
    localparam logic [7:0] WRAP_00   = 8'h00;
`else
    localparam logic [7:0] WRAP_01_A = 8'h99;
    localparam logic [7:0] WRAP_01_B = 8'h98;
    localparam logic [7:0] WRAP_00   = 8'h99;
`endif

    dec_down_counter #(.DIGITS(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .en       (en),
        .count    (count),
        .zero     (zero),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] v);
        load = 1'b1; load_val = v; en = 1'b0;
        tick();
        load = 1'b0;
    endtask

    task automatic test_reset;
        #12;
        checks++; if (count !== 8'h00) begin errors++; $display("FAIL reset_count: got %h want 00", count); end
        checks++; if (zero !== 1'b1) begin errors++; $display("FAIL reset_zero: got %b want 1", zero); end
        checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %b want 0", wrap); end
        #13 reset = 1'b1;
        #3;
    endtask

    task automatic test_count;
        logic [7:0] exp_seq [5];
        exp_seq = '{8'h41, 8'h40, 8'h39, 8'h38, 8'h37};
        do_load(8'h42);
        checks++; if (count !== 8'h42) begin errors++; $display("FAIL load_42: got %h want 42", count); end
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (count !== exp_seq[i]) begin errors++; $display("FAIL count_seq[%0d]: got %h want %h", i, count, exp_seq[i]); end
            checks++; if (zero !== 1'b0) begin errors++; $display("FAIL count_zero[%0d]: got %b want 0", i, zero); end
        end
        en = 1'b0;
    endtask

    task automatic test_wrap;
        do_load(8'h01);
        en = 1'b1;
        tick();
        checks++; if (count !== 8'h00 || zero !== 1'b1 || wrap !== 1'b0) begin errors++; $display("FAIL wrap_at_zero: got count=%h zero=%b wrap=%b want 00/1/0", count, zero, wrap); end
        tick();
        checks++; if (count !== WRAP_01_A || wrap !== 1'b1) begin errors++; $display("FAIL wrap_pulse: got count=%h wrap=%b want %h/1", count, wrap, WRAP_01_A); end
        checks++; if (zero !== (WRAP_01_A == 8'h00)) begin errors++; $display("FAIL wrap_zero: got %b", zero); end
        tick();
        checks++; if (count !== WRAP_01_B || wrap !== 1'b0) begin errors++; $display("FAIL wrap_after: got count=%h wrap=%b want %h/0", count, wrap, WRAP_01_B); end
        en = 1'b0;
    endtask

    task automatic test_saturate_and_priority;
        do_load(8'hAF);
        checks++; if (count !== 8'h99) begin errors++; $display("FAIL sat_load: got %h want 99", count); end
        load = 1'b1; en = 1'b1; load_val = 8'h15;
        tick();
        checks++; if (count !== 8'h15 || wrap !== 1'b0) begin errors++; $display("FAIL load_over_en: got count=%h wrap=%b want 15/0", count, wrap); end
        load = 1'b0; en = 1'b0;
    endtask

    task automatic test_en_toggle;
        logic       en_seq  [4];
        logic [7:0] exp_seq [4];
        en_seq  = '{1'b1, 1'b0, 1'b0, 1'b1};
        exp_seq = '{8'h19, 8'h19, 8'h19, 8'h18};
        do_load(8'h20);
        for (int i = 0; i < 4; i++) begin
            en = en_seq[i];
            tick();
            checks++; if (count !== exp_seq[i] || wrap !== 1'b0) begin errors++; $display("FAIL en_toggle[%0d]: got count=%h wrap=%b want %h/0", i, count, wrap, exp_seq[i]); end
        end
        en = 1'b0;
    endtask

    task automatic test_en_low_drops_wrap;
        do_load(8'h00);
        en = 1'b1;
        tick();
        checks++; if (count !== WRAP_00 || wrap !== 1'b1) begin errors++; $display("FAIL wrap_from_00: got count=%h wrap=%b want %h/1", count, wrap, WRAP_00); end
        en = 1'b0;
        tick();
        checks++; if (count !== WRAP_00 || wrap !== 1'b0) begin errors++; $display("FAIL en_low_hold: got count=%h wrap=%b want %h/0", count, wrap, WRAP_00); end
    endtask

    task automatic test_reset_mid;
        do_load(8'h55);
        en = 1'b1;
        tick();
        tick();
        checks++; if (count !== 8'h53) begin errors++; $display("FAIL pre_reset: got %h want 53", count); end
        #3 reset = 1'b0;
        #1;
        checks++; if (count !== 8'h00 || zero !== 1'b1) begin errors++; $display("FAIL reset_mid: got count=%h zero=%b want 00/1", count, zero); end
        reset = 1'b1;
        en = 1'b0;
        do_load(8'h00);
        en = 1'b1;
        tick();
        checks++; if (wrap !== 1'b1) begin errors++; $display("FAIL wrap_before_cancel: got %b want 1", wrap); end
        #3 reset = 1'b0;
        #1;
        checks++; if (wrap !== 1'b0 || count !== 8'h00) begin errors++; $display("FAIL wrap_cancel: got count=%h wrap=%b want 00/0", count, wrap); end
        en = 1'b0;
        reset = 1'b1;
        tick();
        checks++; if (count !== 8'h00 || wrap !== 1'b0) begin errors++; $display("FAIL after_release: got count=%h wrap=%b want 00/0", count, wrap); end
    endtask

`ifdef DEC_DOWN_AUTO_RELOAD_EN
    task automatic test_auto_reload;
        logic [7:0] exp_seq [5];
        logic       exp_wr  [5];
        exp_seq = '{8'h02, 8'h01, 8'h00, 8'h03, 8'h02};
        exp_wr  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        do_load(8'h03);
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (count !== exp_seq[i] || wrap !== exp_wr[i]) begin errors++; $display("FAIL reload_seq[%0d]: got count=%h wrap=%b want %h/%b", i, count, wrap, exp_seq[i], exp_wr[i]); end
        end
        do_load(8'h00);
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (count !== 8'h00 || wrap !== 1'b1) begin errors++; $display("FAIL reload_zero[%0d]: got count=%h wrap=%b want 00/1", i, count, wrap); end
        end
        en = 1'b0;
    endtask
`endif

    initial begin
        reset = 1'b0; load = 1'b0; en = 1'b0; load_val = 8'h00;
        test_reset();
        test_count();
        test_wrap();
        test_saturate_and_priority();
        test_en_toggle();
        test_en_low_drops_wrap();
        test_reset_mid();
`ifdef DEC_DOWN_AUTO_RELOAD_EN
        test_auto_reload();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
